// File: rtl/bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter (double dabble).
// One shift/add-3 iteration per clock, with raw bypass and saturation.
module bcd_seq_ctrl #(
  parameter int          BIN_W   = 14,
  parameter int          DIGITS  = 4,
  parameter logic [31:0] MAX_VAL = 32'd9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] binary,
  input  logic        flag,
  output logic        busy,
  output logic        done,
  output logic [31:0] output_bcd,
  output logic        overflow
);

  localparam int CW = $clog2(BIN_W);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_FIN   = 2'd2;

  logic [1:0]          state;
  logic [31:0]         raw;
  logic                byp;
  logic                sat;
  logic [BIN_W-1:0]    shreg;
  logic [4*DIGITS-1:0] dig;
  logic [4*DIGITS-1:0] dig_adj;
  logic [CW-1:0]       cnt;
  logic [31:0]         sat_val;
  logic [31:0]         pad;

  // Clamp the full 32-bit input to the displayable range
  always_comb begin
    sat_val = (binary > MAX_VAL) ? MAX_VAL : binary;
  end

  // Add 3 to every digit that would overflow a decade on the shift
  always_comb begin
    dig_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig[4*i +: 4] >= 4'd5)
        dig_adj[4*i +: 4] = dig[4*i +: 4] + 4'd3;
      else
        dig_adj[4*i +: 4] = dig[4*i +: 4];
    end
  end

  // Spread digits onto byte lanes, upper nibble of each lane zero
  always_comb begin
    pad = '0;
    for (int i = 0; i < DIGITS; i++) begin
      pad[8*i +: 4] = dig[4*i +: 4];
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      raw        <= '0;
      byp        <= 1'b0;
      sat        <= 1'b0;
      shreg      <= '0;
      dig        <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      output_bcd <= '0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            raw  <= binary;
            byp  <= flag;
            busy <= 1'b1;
            if (flag) begin
              state <= S_FIN;
            end else begin
              shreg <= sat_val[BIN_W-1:0];
              sat   <= (binary > MAX_VAL);
              dig   <= '0;
              cnt   <= '0;
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          dig   <= {dig_adj[4*DIGITS-2:0], shreg[BIN_W-1]};
          shreg <= {shreg[BIN_W-2:0], 1'b0};
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(BIN_W - 1))
            state <= S_FIN;
        end
        S_FIN: begin
          output_bcd <= byp ? raw : pad;
          overflow   <= byp ? 1'b0 : sat;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
